// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, pattern encoding and colour helpers for the VGA pixel path.
package vga_pkg;

  localparam int H_TOTAL      = 800;
  localparam int V_TOTAL      = 525;
  localparam int H_SYNC_LEN   = 96;
  localparam int H_BACK_PORCH = 48;
  localparam int V_SYNC_LEN   = 2;
  localparam int V_BACK_PORCH = 33;
  localparam int H_VIS        = 640;
  localparam int V_VIS        = 480;
  localparam int H_VIS_START  = H_SYNC_LEN + H_BACK_PORCH;
  localparam int V_VIS_START  = V_SYNC_LEN + V_BACK_PORCH;

  localparam int COLOR_W   = 4;
  localparam int BAR_LEN   = 16;
  localparam int BAR_STEP  = 4;
  localparam int BAR_X_MAX = H_VIS - BAR_STEP;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_GRAD    = 2'd2,
    PAT_BAR     = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Expand a {r,g,b} on/off mask into full-scale channels.
  function automatic rgb_t rgb_from_mask(input logic [2:0] m);
    rgb_t c;
    c.r = {COLOR_W{m[2]}};
    c.g = {COLOR_W{m[1]}};
    c.b = {COLOR_W{m[0]}};
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stable-level debouncer and a one-cycle press pulse.
module btn_debounce #(
  parameter int CYCLES     = 250000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic pixel_clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  // Synchroniser holds the "pressed" polarity so a cleared register means released.
  logic [1:0]       sync_reg;
  logic             level_reg;
  logic [CNT_W-1:0] count_reg;
  logic             press_reg;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      count_reg <= '0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn ^ ACTIVE_LOW};
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        count_reg <= '0;
      end else if (count_reg == CNT_W'(CYCLES - 1)) begin
        count_reg <= '0;
        level_reg <= sync_reg[1];
        press_reg <= sync_reg[1];
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage pixel pipeline after the VGA timing counter: four selectable test patterns,
// syncs and DE delayed to match, mode changes deferred to frame start.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE_START  = H_VIS_START,
  parameter int V_ACTIVE_START  = V_VIS_START,
  parameter int H_ACTIVE        = H_VIS,
  parameter int V_ACTIVE        = V_VIS,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic [9:0]         h_counter,
  input  logic [9:0]         v_counter,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic               btn,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic               de_out,
  output logic [1:0]         mode
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic press;

  btn_debounce #(
    .CYCLES    (DEBOUNCE_CYCLES),
    .ACTIVE_LOW(BTN_ACTIVE_LOW)
  ) u_btn_debounce (
    .pixel_clk(pixel_clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .press    (press)
  );

  // Mode, pending press and moving-bar position only change at frame start.
  logic     frame_start;
  pattern_e mode_reg;
  logic     pending_reg;
  logic [9:0] bar_x_reg;

  assign frame_start = (h_counter == 10'd0) && (v_counter == 10'd0);

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      mode_reg    <= PAT_BARS;
      pending_reg <= 1'b0;
      bar_x_reg   <= '0;
    end else if (frame_start) begin
      if (pending_reg) mode_reg <= pattern_e'(mode_reg + 2'd1);
      pending_reg <= press;
      bar_x_reg   <= (bar_x_reg >= 10'(BAR_X_MAX)) ? 10'd0 : bar_x_reg + 10'(BAR_STEP);
    end else if (press) begin
      pending_reg <= 1'b1;
    end
  end

  assign mode = mode_reg;

  // Stage 1: visibility, pixel coordinates, syncs and the per-frame pattern state.
  logic       active_next;
  logic       active_reg;
  logic [9:0] x_reg;
  logic [3:0] y_blk_reg;
  logic       hs1_reg;
  logic       vs1_reg;
  pattern_e   mode1_reg;
  logic [9:0] bar1_reg;

  assign active_next = (h_counter >= 10'(H_ACTIVE_START)) &&
                       (h_counter <  10'(H_ACTIVE_START + H_ACTIVE)) &&
                       (v_counter >= 10'(V_ACTIVE_START)) &&
                       (v_counter <  10'(V_ACTIVE_START + V_ACTIVE));

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      active_reg <= 1'b0;
      x_reg      <= '0;
      y_blk_reg  <= '0;
      hs1_reg    <= 1'b0;
      vs1_reg    <= 1'b0;
      mode1_reg  <= PAT_BARS;
      bar1_reg   <= '0;
    end else begin
      active_reg <= active_next;
      x_reg      <= h_counter - 10'(H_ACTIVE_START);
      // Only y[8:5] feeds any pattern (32-line blocks).
      y_blk_reg  <= 4'((v_counter - 10'(V_ACTIVE_START)) >> 5);
      hs1_reg    <= h_sync_in;
      vs1_reg    <= v_sync_in;
      mode1_reg  <= mode_reg;
      bar1_reg   <= bar_x_reg;
    end
  end

  // Bar index = number of 80-pixel boundaries already passed.
  logic [6:0] bar_edge;
  logic [2:0] bar_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_bar_edge
      assign bar_edge[gi] = (x_reg >= 10'((gi + 1) * BAR_W));
    end
  endgenerate

  assign bar_idx = 3'($countones(bar_edge));

  // x never exceeds 639 while active, so the right-edge clamp is implicit.
  logic in_bar;
  assign in_bar = ({1'b0, x_reg} >= {1'b0, bar1_reg}) &&
                  ({1'b0, x_reg} <= {1'b0, bar1_reg} + 11'(BAR_LEN - 1));

  rgb_t color_next;

  always_comb begin
    color_next = '0;
    case (mode1_reg)
      PAT_BARS:    color_next = rgb_from_mask({~bar_idx[1], ~bar_idx[2], ~bar_idx[0]});
      PAT_CHECKER: color_next = rgb_from_mask({3{x_reg[5] ^ y_blk_reg[0]}});
      PAT_GRAD: begin
        color_next.r = x_reg[9:6];
        color_next.g = y_blk_reg;
      end
      PAT_BAR:     color_next = in_bar ? rgb_from_mask(3'b111) : rgb_from_mask(3'b001);
      default:     color_next = '0;
    endcase
    if (!active_reg) color_next = '0;
  end

  // Stage 2: output registers.
  rgb_t color_reg;
  logic hs2_reg;
  logic vs2_reg;
  logic de_reg;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      color_reg <= '0;
      hs2_reg   <= 1'b0;
      vs2_reg   <= 1'b0;
      de_reg    <= 1'b0;
    end else begin
      color_reg <= color_next;
      hs2_reg   <= hs1_reg;
      vs2_reg   <= vs1_reg;
      de_reg    <= active_reg;
    end
  end

  assign red        = color_reg.r;
  assign green      = color_reg.g;
  assign blue       = color_reg.b;
  assign h_sync_out = hs2_reg;
  assign v_sync_out = vs2_reg;
  assign de_out     = de_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed counter/button stimulus, a per-cycle pixel model and literal spot checks.
module tb_vga_pattern_gen;

  logic       pixel_clk = 1'b0;
  logic       rst_n     = 1'b0;
  logic [9:0] h_counter = '0;
  logic [9:0] v_counter = '0;
  logic       h_sync_in = 1'b0;
  logic       v_sync_in = 1'b0;
  logic       btn       = 1'b1;
  logic [3:0] red, green, blue;
  logic       h_sync_out, v_sync_out, de_out;
  logic [1:0] mode;

  always #20 pixel_clk = ~pixel_clk;

  vga_pattern_gen #(
    .DEBOUNCE_CYCLES(4),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .h_counter (h_counter),
    .v_counter (v_counter),
    .h_sync_in (h_sync_in),
    .v_sync_in (v_sync_in),
    .btn       (btn),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out),
    .de_out    (de_out),
    .mode      (mode)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Inputs seen at one clock edge, plus the pattern state in force before that edge.
  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit rst;
    int mode;
    int bar;
  } rec_t;

  rec_t prev_r, cur_r;
  int   mode_m = 0;
  int   bar_m  = 0;
  bit   pend_m = 1'b0;
  int   exp_r, exp_g, exp_b, exp_mode;
  bit   exp_hs, exp_vs, exp_de;
  bit   exp_valid = 1'b0;

  int bar_tab [8][3] = '{'{15,15,15}, '{15,15,0}, '{0,15,15}, '{0,15,0},
                         '{15,0,15},  '{15,0,0},  '{0,0,15},  '{0,0,0}};

  function automatic void pixel_model(input rec_t p, output int r, output int g,
                                      output int b, output bit de);
    int x, y, hi;
    r = 0; g = 0; b = 0; de = 1'b0;
    if (p.h >= 144 && p.h < 784 && p.v >= 35 && p.v < 515) begin
      de = 1'b1;
      x  = p.h - 144;
      y  = p.v - 35;
      case (p.mode)
        0: begin r = bar_tab[x/80][0]; g = bar_tab[x/80][1]; b = bar_tab[x/80][2]; end
        1: if ((((x / 32) + (y / 32)) % 2) == 1) begin r = 15; g = 15; b = 15; end
        2: begin r = x / 64; g = y / 32; end
        default: begin
          hi = (p.bar + 15 < 639) ? p.bar + 15 : 639;
          if (x >= p.bar && x <= hi) begin r = 15; g = 15; b = 15; end
          else b = 15;
        end
      endcase
    end
  endfunction

  // Model: outputs after edge t follow inputs of edge t-1 unless either edge was in reset.
  always @(posedge pixel_clk) begin
    prev_r      = cur_r;
    cur_r.h     = int'(h_counter);
    cur_r.v     = int'(v_counter);
    cur_r.hs    = h_sync_in;
    cur_r.vs    = v_sync_in;
    cur_r.rst   = rst_n;
    cur_r.mode  = mode_m;
    cur_r.bar   = bar_m;
    if (cur_r.rst && prev_r.rst) begin
      pixel_model(prev_r, exp_r, exp_g, exp_b, exp_de);
      exp_hs = prev_r.hs;
      exp_vs = prev_r.vs;
    end else begin
      exp_r = 0; exp_g = 0; exp_b = 0; exp_de = 1'b0; exp_hs = 1'b0; exp_vs = 1'b0;
    end
    if (!rst_n) begin
      mode_m = 0; bar_m = 0; pend_m = 1'b0;
    end else if (h_counter == 10'd0 && v_counter == 10'd0) begin
      if (pend_m) mode_m = (mode_m + 1) % 4;
      pend_m = 1'b0;
      bar_m  = (bar_m >= 636) ? 0 : bar_m + 4;
    end
    exp_mode  = mode_m;
    exp_valid = 1'b1;
  end

  always @(negedge pixel_clk) begin
    if (exp_valid) begin
      n_cmp++;
      if (red !== 4'(exp_r) || green !== 4'(exp_g) || blue !== 4'(exp_b) ||
          h_sync_out !== exp_hs || v_sync_out !== exp_vs || de_out !== exp_de ||
          mode !== 2'(exp_mode)) begin
        n_bad++;
        $display("FAIL cycle t=%0t got rgb=%h/%h/%h hs=%b vs=%b de=%b mode=%0d want rgb=%h/%h/%h hs=%b vs=%b de=%b mode=%0d",
                 $time, red, green, blue, h_sync_out, v_sync_out, de_out, mode,
                 exp_r, exp_g, exp_b, exp_hs, exp_vs, exp_de, exp_mode);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive(input int h, input int v);
    h_counter = 10'(h);
    v_counter = 10'(v);
    h_sync_in = (h < 96);
    v_sync_in = (v < 2);
    @(negedge pixel_clk);
  endtask

  // Hold the button long enough to be accepted, then release it; all on line v.
  task automatic press(input int v);
    for (int i = 0; i < 24; i++) begin
      btn = (i < 12) ? 1'b0 : 1'b1;
      drive(300 + i, v);
    end
    pend_m = 1'b1;
  endtask

  int first_de;
  int lines [4] = '{1, 34, 35, 36};

  initial begin
    // Reset with counters running
    for (int i = 0; i < 5; i++) drive(i, 0);
    lit("reset_rgb", {red, green, blue}, 0);
    lit("reset_sync_de", {h_sync_out, v_sync_out, de_out}, 0);
    lit("reset_mode", mode, 0);
    rst_n = 1'b1;

    // Alignment across full lines
    drive(0, 0);
    first_de = -1;
    foreach (lines[li]) begin
      for (int h = 0; h < 800; h++) begin
        drive(h, lines[li]);
        if (lines[li] == 35 && de_out && first_de < 0) first_de = h;
        if (lines[li] == 36 && h == 96) lit("hsync_tail", h_sync_out, 1);
        if (lines[li] == 36 && h == 97) lit("hsync_off", h_sync_out, 0);
      end
    end
    lit("first_de_h", first_de, 145);

    // Colour bars
    drive(144, 35); drive(145, 35); lit("bars_white", {red, green, blue}, 12'hFFF);
    drive(224, 35); drive(225, 35); lit("bars_yellow", {red, green, blue}, 12'hFF0);
    drive(704, 35); drive(705, 35); lit("bars_black", {red, green, blue}, 12'h000);
    drive(100, 35); drive(101, 35); lit("bars_blank", {red, green, blue}, 12'h000);

    // Button -> checker
    press(200);
    lit("mode_held", mode, 0);
    drive(0, 0); drive(1, 0);
    lit("mode_checker", mode, 1);
    drive(176, 35); drive(177, 35); lit("chk_x32_y0", {red, green, blue}, 12'hFFF);
    drive(144, 35); drive(145, 35); lit("chk_x0_y0", {red, green, blue}, 12'h000);
    drive(144, 67); drive(145, 67); lit("chk_x0_y32", {red, green, blue}, 12'hFFF);

    // Two presses in one frame advance once
    press(200);
    press(210);
    drive(0, 0); drive(1, 0);
    lit("mode_double", mode, 2);
    drive(720, 483); drive(721, 483); lit("grad_9_14", {red, green, blue}, 12'h9E0);

    // Moving bar, across the wrap
    press(200);
    drive(0, 0); drive(1, 0);
    lit("mode_bar", mode, 3);
    for (int f = 0; f < 162; f++) begin
      drive(0, 0);
      for (int h = 142 + bar_m; h < 162 + bar_m; h++) drive(h, 40);
      if (bar_m == 636) begin
        drive(783, 40); drive(784, 40); lit("bar636_x639", {red, green, blue}, 12'hFFF);
        drive(785, 40); lit("bar636_h784", {red, green, blue}, 12'h000);
      end
      if (bar_m == 0) begin
        drive(159, 40); drive(160, 40); lit("bar0_x15", {red, green, blue}, 12'hFFF);
        drive(161, 40); lit("bar0_x16", {red, green, blue}, 12'h00F);
      end
    end

    // Mid-frame reset
    for (int h = 395; h < 400; h++) drive(h, 300);
    rst_n = 1'b0;
    drive(400, 300);
    lit("midrst_rgb", {red, green, blue}, 0);
    lit("midrst_sync_de", {h_sync_out, v_sync_out, de_out}, 0);
    lit("midrst_mode", mode, 0);
    drive(401, 300); drive(402, 300);
    rst_n = 1'b1;
    for (int h = 403; h < 500; h++) drive(h, 300);

    // bar_x restarts from 0: three frames later it sits at 12
    for (int k = 0; k < 3; k++) begin
      press(200);
      drive(0, 0);
    end
    lit("postrst_mode", mode, 3);
    drive(156, 40); drive(157, 40); lit("postrst_x12", {red, green, blue}, 12'hFFF);
    drive(158, 40);
    drive(155, 40); drive(156, 40); lit("postrst_x11", {red, green, blue}, 12'h00F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
